axi_gp0_reg_ctrl: RTL and testbench

//  AXI3 slave controller for the Zynq M_AXI_GP0 port: sequences read/write bursts (len<=16, 32-bit beats) onto a

---
 rtl/axi_gp0_pkg.sv | 43 ++++
 rtl/axi_gp0_addr_gen.sv | 27 ++
 rtl/axi_gp0_reg_ctrl.sv | 262 ++++++++++++++++++++++++++
 tb/tb_axi_gp0_reg_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_gp0_pkg.sv
// rtl/axi_gp0_pkg.sv - shared constants, types and burst legality check for the GP0 register controller
package axi_gp0_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [2:0] SIZE_32 = 3'b010;

  localparam int BEAT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_DATA,
    ST_WR_RESP,
    ST_RD_REQ,
    ST_RD_CAP,
    ST_RD_DATA
  } state_t;

  // Address-phase attributes shared by AW and AR once a side is granted
  typedef struct packed {
    logic [31:0]       addr;
    logic [BEAT_W-1:0] len;
    logic [1:0]        burst;
    logic [2:0]        size;
  } addr_req_t;

  // Only full-word beats and legal burst types are accepted; WRAP needs 2/4/8/16 beats
  function automatic logic [1:0] burst_check(input logic [2:0] size, input logic [1:0] burst,
                                             input logic [BEAT_W-1:0] len);
    logic wrap_ok;
    wrap_ok = (len != 4'd0) && ((len & (len + 4'd1)) == 4'd0);
    if (size != SIZE_32 || burst == 2'b11 || (burst == BURST_WRAP && !wrap_ok))
      return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi_gp0_addr_gen.sv
// rtl/axi_gp0_addr_gen.sv - next beat address for FIXED/INCR/WRAP bursts inside the register window
module axi_gp0_addr_gen
  import axi_gp0_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic [AW-1:0]     addr,
  input  logic [BEAT_W-1:0] len,
  input  logic [1:0]        burst,
  output logic [AW-1:0]     next_addr
);

  logic [AW-1:0] incr;
  logic [AW-1:0] mask;

  // INCR wraps naturally at the window size because the offset is only AW bits wide
  always_comb begin
    incr = addr + AW'(4);
    mask = ((AW'(len) + AW'(1)) << 2) - AW'(1);
    case (burst)
      BURST_INCR: next_addr = incr;
      BURST_WRAP: next_addr = (addr & ~mask) | (incr & mask);
      default:    next_addr = addr;
    endcase
  end

endmodule

// File: rtl/axi_gp0_reg_ctrl.sv
// rtl/axi_gp0_reg_ctrl.sv - AXI3 GP0 slave sequencing bursts onto one register port; option AXI_GP0_ERR_IRQ_EN
module axi_gp0_reg_ctrl
  import axi_gp0_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int          REG_AW    = 8,
  parameter int          ID_W      = 12
) (
  input  logic              M_AXI_GP0_aclk,
  input  logic              M_AXI_GP0_aresetn,
  input  logic [31:0]       M_AXI_GP0_awaddr,
  input  logic [3:0]        M_AXI_GP0_awlen,
  input  logic [1:0]        M_AXI_GP0_awburst,
  input  logic [2:0]        M_AXI_GP0_awsize,
  input  logic [ID_W-1:0]   M_AXI_GP0_awid,
  input  logic              M_AXI_GP0_awvalid,
  output logic              M_AXI_GP0_awready,
  input  logic [31:0]       M_AXI_GP0_wdata,
  input  logic [3:0]        M_AXI_GP0_wstrb,
  input  logic              M_AXI_GP0_wlast,
  input  logic              M_AXI_GP0_wvalid,
  output logic              M_AXI_GP0_wready,
  output logic [ID_W-1:0]   M_AXI_GP0_bid,
  output logic [1:0]        M_AXI_GP0_bresp,
  output logic              M_AXI_GP0_bvalid,
  input  logic              M_AXI_GP0_bready,
  input  logic [31:0]       M_AXI_GP0_araddr,
  input  logic [3:0]        M_AXI_GP0_arlen,
  input  logic [1:0]        M_AXI_GP0_arburst,
  input  logic [2:0]        M_AXI_GP0_arsize,
  input  logic [ID_W-1:0]   M_AXI_GP0_arid,
  input  logic              M_AXI_GP0_arvalid,
  output logic              M_AXI_GP0_arready,
  output logic [31:0]       M_AXI_GP0_rdata,
  output logic [ID_W-1:0]   M_AXI_GP0_rid,
  output logic [1:0]        M_AXI_GP0_rresp,
  output logic              M_AXI_GP0_rlast,
  output logic              M_AXI_GP0_rvalid,
  input  logic              M_AXI_GP0_rready,
`ifdef AXI_GP0_ERR_IRQ_EN
  output logic              err_irq,
  output logic [3:0]        err_status,
  input  logic              err_clr,
`endif
  output logic              reg_en,
  output logic              reg_we,
  output logic [REG_AW-1:0] reg_addr,
  output logic [31:0]       reg_wdata,
  output logic [3:0]        reg_wstrb,
  input  logic [31:0]       reg_rdata
);

  localparam int OFF_W = REG_AW + 2;
  localparam logic [32:0] WIN_LO = {1'b0, BASE_ADDR};
  localparam logic [32:0] WIN_HI = WIN_LO + (33'd4 << REG_AW);

  logic clk;
  logic rst_n;
  assign clk   = M_AXI_GP0_aclk;
  assign rst_n = M_AXI_GP0_aresetn;

  state_t            state;
  logic              rr_wr;
  logic [OFF_W-1:0]  cur_addr;
  logic [OFF_W-1:0]  next_addr;
  logic [BEAT_W-1:0] len_q;
  logic [BEAT_W-1:0] beat;
  logic [1:0]        burst_q;
  logic [1:0]        ap_resp;
  logic              wl_err;

  logic              grant_wr;
  logic              grant_rd;
  addr_req_t         sel;
  logic [1:0]        sel_resp;
  logic [OFF_W-1:0]  sel_off;

  logic              wr_fire;
  logic              wr_last;
  logic              wlast_bad;
  logic              ap_ok;

  // Round-robin pick when both address channels request; pick selected side's attributes and classify
  always_comb begin
    grant_wr = M_AXI_GP0_awvalid && (!M_AXI_GP0_arvalid || rr_wr);
    grant_rd = M_AXI_GP0_arvalid && (!M_AXI_GP0_awvalid || !rr_wr);
    if (grant_wr)
      sel = '{addr: M_AXI_GP0_awaddr, len: M_AXI_GP0_awlen, burst: M_AXI_GP0_awburst, size: M_AXI_GP0_awsize};
    else
      sel = '{addr: M_AXI_GP0_araddr, len: M_AXI_GP0_arlen, burst: M_AXI_GP0_arburst, size: M_AXI_GP0_arsize};
    sel_off = sel.addr[OFF_W-1:0] - BASE_ADDR[OFF_W-1:0];
    if ({1'b0, sel.addr} < WIN_LO || {1'b0, sel.addr} >= WIN_HI)
      sel_resp = RESP_DECERR;
    else
      sel_resp = burst_check(sel.size, sel.burst, sel.len);
  end

  axi_gp0_addr_gen #(.AW(OFF_W)) u_addr_gen (
    .addr      (cur_addr),
    .len       (len_q),
    .burst     (burst_q),
    .next_addr (next_addr)
  );

  assign ap_ok     = (ap_resp == RESP_OKAY);
  assign wr_fire   = (state == ST_WR_DATA) && M_AXI_GP0_wvalid && M_AXI_GP0_wready;
  assign wr_last   = (beat == len_q);
  assign wlast_bad = (M_AXI_GP0_wlast != wr_last);

  // Register strobe: write beats pass straight through from W, reads strobe for the RD_REQ cycle
  always_comb begin
    reg_en    = 1'b0;
    reg_we    = 1'b0;
    reg_addr  = '0;
    reg_wdata = '0;
    reg_wstrb = '0;
    if (wr_fire) begin
      reg_en    = ap_ok;
      reg_we    = ap_ok;
      reg_addr  = cur_addr[OFF_W-1:2];
      reg_wdata = M_AXI_GP0_wdata;
      reg_wstrb = M_AXI_GP0_wstrb;
    end else if (state == ST_RD_REQ) begin
      reg_en   = ap_ok;
      reg_addr = cur_addr[OFF_W-1:2];
    end
  end

  // Transaction sequencer: grant, beat stepping, B/R response generation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= ST_IDLE;
      rr_wr             <= 1'b1;
      cur_addr          <= '0;
      len_q             <= '0;
      beat              <= '0;
      burst_q           <= '0;
      ap_resp           <= RESP_OKAY;
      wl_err            <= 1'b0;
      M_AXI_GP0_awready <= 1'b0;
      M_AXI_GP0_arready <= 1'b0;
      M_AXI_GP0_wready  <= 1'b0;
      M_AXI_GP0_bvalid  <= 1'b0;
      M_AXI_GP0_bresp   <= RESP_OKAY;
      M_AXI_GP0_bid     <= '0;
      M_AXI_GP0_rvalid  <= 1'b0;
      M_AXI_GP0_rdata   <= '0;
      M_AXI_GP0_rresp   <= RESP_OKAY;
      M_AXI_GP0_rid     <= '0;
      M_AXI_GP0_rlast   <= 1'b0;
    end else begin
      M_AXI_GP0_awready <= 1'b0;
      M_AXI_GP0_arready <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_wr || grant_rd) begin
            cur_addr <= sel_off;
            len_q    <= sel.len;
            burst_q  <= sel.burst;
            ap_resp  <= sel_resp;
            beat     <= '0;
            wl_err   <= 1'b0;
            if (M_AXI_GP0_awvalid && M_AXI_GP0_arvalid)
              rr_wr <= !grant_wr;
            if (grant_wr) begin
              M_AXI_GP0_awready <= 1'b1;
              M_AXI_GP0_wready  <= 1'b1;
              M_AXI_GP0_bid     <= M_AXI_GP0_awid;
              state             <= ST_WR_DATA;
            end else begin
              M_AXI_GP0_arready <= 1'b1;
              M_AXI_GP0_rid     <= M_AXI_GP0_arid;
              state             <= ST_RD_REQ;
            end
          end
        end
        ST_WR_DATA: begin
          if (wr_fire) begin
            beat     <= beat + 4'd1;
            cur_addr <= next_addr;
            wl_err   <= wl_err | wlast_bad;
            if (wr_last) begin
              M_AXI_GP0_wready <= 1'b0;
              M_AXI_GP0_bvalid <= 1'b1;
              if (!ap_ok)
                M_AXI_GP0_bresp <= ap_resp;
              else if (wl_err || wlast_bad)
                M_AXI_GP0_bresp <= RESP_SLVERR;
              else
                M_AXI_GP0_bresp <= RESP_OKAY;
              state <= ST_WR_RESP;
            end
          end
        end
        ST_WR_RESP: begin
          if (M_AXI_GP0_bready) begin
            M_AXI_GP0_bvalid <= 1'b0;
            state            <= ST_IDLE;
          end
        end
        ST_RD_REQ: begin
          state <= ST_RD_CAP;
        end
        ST_RD_CAP: begin
          M_AXI_GP0_rdata  <= ap_ok ? reg_rdata : 32'd0;
          M_AXI_GP0_rresp  <= ap_resp;
          M_AXI_GP0_rlast  <= wr_last;
          M_AXI_GP0_rvalid <= 1'b1;
          state            <= ST_RD_DATA;
        end
        ST_RD_DATA: begin
          if (M_AXI_GP0_rready) begin
            M_AXI_GP0_rvalid <= 1'b0;
            M_AXI_GP0_rlast  <= 1'b0;
            if (M_AXI_GP0_rlast) begin
              state <= ST_IDLE;
            end else begin
              beat     <= beat + 4'd1;
              cur_addr <= next_addr;
              state    <= ST_RD_REQ;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef AXI_GP0_ERR_IRQ_EN
  logic       b_fire;
  logic       r_fire;
  logic [3:0] err_set;

  assign b_fire = (state == ST_WR_RESP) && M_AXI_GP0_bvalid && M_AXI_GP0_bready;
  assign r_fire = (state == ST_RD_DATA) && M_AXI_GP0_rvalid && M_AXI_GP0_rready;

  // Error bits raised by the accepted response that carries them
  always_comb begin
    err_set = 4'b0000;
    if (b_fire || r_fire) begin
      err_set[2] = (ap_resp == RESP_SLVERR);
      err_set[1] = (ap_resp == RESP_DECERR);
    end
    if (b_fire)
      err_set[3] = wl_err;
    if (r_fire)
      err_set[0] = !ap_ok;
  end

  // Sticky status with clear; a new error in the clear cycle survives
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_status <= 4'b0000;
      err_irq    <= 1'b0;
    end else begin
      err_status <= (err_clr ? 4'b0000 : err_status) | err_set;
      err_irq    <= |err_status;
    end
  end
`endif

endmodule

// File: tb/tb_axi_gp0_reg_ctrl.sv
// tb/tb_axi_gp0_reg_ctrl.sv - directed bench for axi_gp0_reg_ctrl
module tb_axi_gp0_reg_ctrl;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam logic [1:0]  FIX  = 2'b00;
  localparam logic [1:0]  INC  = 2'b01;
  localparam logic [1:0]  WRP  = 2'b10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] awaddr, araddr, wdata, rdata, reg_wdata, reg_rdata;
  logic [3:0]  awlen, arlen, wstrb, reg_wstrb;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic [2:0]  awsize, arsize;
  logic [11:0] awid, arid, bid, rid;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        reg_en, reg_we;
  logic [7:0]  reg_addr;
`ifdef AXI_GP0_ERR_IRQ_EN
  logic        err_irq, err_clr;
  logic [3:0]  err_status;
`endif

  int n_err = 0;
  int n_chk = 0;

  logic [31:0] mem [0:255];
  logic [7:0]  log_addr [0:63];
  logic        log_we [0:63];
  int          log_n = 0;

  logic [31:0] r_data [0:15];
  logic [1:0]  r_resp [0:15];
  logic        r_last [0:15];
  logic [11:0] r_id [0:15];
  logic [1:0]  b_resp_s;
  logic [11:0] b_id_s;

  always #5 clk = ~clk;

  axi_gp0_reg_ctrl dut (
    .M_AXI_GP0_aclk(clk), .M_AXI_GP0_aresetn(rst_n),
    .M_AXI_GP0_awaddr(awaddr), .M_AXI_GP0_awlen(awlen), .M_AXI_GP0_awburst(awburst),
    .M_AXI_GP0_awsize(awsize), .M_AXI_GP0_awid(awid), .M_AXI_GP0_awvalid(awvalid),
    .M_AXI_GP0_awready(awready),
    .M_AXI_GP0_wdata(wdata), .M_AXI_GP0_wstrb(wstrb), .M_AXI_GP0_wlast(wlast),
    .M_AXI_GP0_wvalid(wvalid), .M_AXI_GP0_wready(wready),
    .M_AXI_GP0_bid(bid), .M_AXI_GP0_bresp(bresp), .M_AXI_GP0_bvalid(bvalid), .M_AXI_GP0_bready(bready),
    .M_AXI_GP0_araddr(araddr), .M_AXI_GP0_arlen(arlen), .M_AXI_GP0_arburst(arburst),
    .M_AXI_GP0_arsize(arsize), .M_AXI_GP0_arid(arid), .M_AXI_GP0_arvalid(arvalid),
    .M_AXI_GP0_arready(arready),
    .M_AXI_GP0_rdata(rdata), .M_AXI_GP0_rid(rid), .M_AXI_GP0_rresp(rresp), .M_AXI_GP0_rlast(rlast),
    .M_AXI_GP0_rvalid(rvalid), .M_AXI_GP0_rready(rready),
`ifdef AXI_GP0_ERR_IRQ_EN
    .err_irq(err_irq), .err_status(err_status), .err_clr(err_clr),
`endif
    .reg_en(reg_en), .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_wstrb(reg_wstrb), .reg_rdata(reg_rdata)
  );

  // Register bank model: byte-enabled writes, read data one cycle after the strobe
  always @(posedge clk) begin
    if (reg_en && reg_we)
      for (int b = 0; b < 4; b++)
        if (reg_wstrb[b]) mem[reg_addr][8*b +: 8] <= reg_wdata[8*b +: 8];
    if (reg_en && !reg_we)
      reg_rdata <= mem[reg_addr];
  end

  // Log every register strobe
  always @(posedge clk) begin
    if (reg_en) begin
      log_addr[log_n[5:0]] <= reg_addr;
      log_we[log_n[5:0]]   <= reg_we;
      log_n                <= log_n + 1;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_aw(input logic [31:0] a, input logic [3:0] l, input logic [1:0] bu,
                        input logic [2:0] sz, input logic [11:0] id);
    awaddr = a; awlen = l; awburst = bu; awsize = sz; awid = id; awvalid = 1'b1;
  endtask

  task automatic set_ar(input logic [31:0] a, input logic [3:0] l, input logic [1:0] bu,
                        input logic [2:0] sz, input logic [11:0] id);
    araddr = a; arlen = l; arburst = bu; arsize = sz; arid = id; arvalid = 1'b1;
  endtask

  task automatic wait_aw();
    int n = 0;
    @(negedge clk);
    while (!awready && n < 40) begin @(negedge clk); n++; end
    check("aw_handshake", awready, 1);
    @(posedge clk); #1 awvalid = 1'b0;
  endtask

  task automatic wait_ar();
    int n = 0;
    @(negedge clk);
    while (!arready && n < 40) begin @(negedge clk); n++; end
    check("ar_handshake", arready, 1);
    @(posedge clk); #1 arvalid = 1'b0;
  endtask

  task automatic send_w(input int nb, input int last_idx, input logic [31:0] dbase);
    for (int k = 0; k < nb; k++) begin
      int n = 0;
      wdata = dbase + k; wstrb = 4'hF; wlast = (k == last_idx); wvalid = 1'b1;
      @(negedge clk);
      while (!wready && n < 40) begin @(negedge clk); n++; end
      check("w_handshake", wready, 1);
      @(posedge clk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic get_b();
    int n = 0;
    bready = 1'b1;
    @(negedge clk);
    while (!bvalid && n < 40) begin @(negedge clk); n++; end
    check("b_handshake", bvalid, 1);
    b_resp_s = bresp; b_id_s = bid;
    @(posedge clk); #1 bready = 1'b0;
  endtask

  task automatic get_r(input int nb);
    rready = 1'b1;
    for (int k = 0; k < nb; k++) begin
      int n = 0;
      @(negedge clk);
      while (!rvalid && n < 40) begin @(negedge clk); n++; end
      check("r_handshake", rvalid, 1);
      r_data[k] = rdata; r_resp[k] = rresp; r_last[k] = rlast; r_id[k] = rid;
      @(posedge clk); #1;
    end
    rready = 1'b0;
  endtask

  task automatic arb_first(output int f);
    int n = 0;
    f = 0;
    while (f == 0 && n < 40) begin
      @(negedge clk);
      if (awready) f = 1;
      else if (arready) f = 2;
      n++;
    end
  endtask

  initial begin
    int base;
    int first;
    logic [3:0]  exp_addr [0:3];
    rst_n = 1'b0;
    awaddr = '0; awlen = '0; awburst = '0; awsize = '0; awid = '0; awvalid = 1'b0;
    araddr = '0; arlen = '0; arburst = '0; arsize = '0; arid = '0; arvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0; rready = 1'b0;
`ifdef AXI_GP0_ERR_IRQ_EN
    err_clr = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_awready", awready, 0);
    check("rst_arready", arready, 0);
    check("rst_wready", wready, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_rlast", rlast, 0);
    check("rst_reg_en", reg_en, 0);
    check("rst_reg_addr", reg_addr, 0);
    check("rst_bresp_bid", {bresp, bid}, 0);
    check("rst_rdata", rdata, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;

    // Arbitration round 1: write first after reset
    set_aw(BASE + 32'h40, 4'd0, INC, 3'b010, 12'h101);
    set_ar(BASE + 32'h40, 4'd0, INC, 3'b010, 12'h202);
    arb_first(first);
    check("arb_round1_first", first, 1);
    @(posedge clk); #1 awvalid = 1'b0;
    send_w(1, 0, 32'h2222_0000);
    get_b();
    check("arb1_bresp", b_resp_s, 2'b00);
    check("arb1_bid", b_id_s, 12'h101);
    wait_ar();
    get_r(1);
    check("arb1_rdata", r_data[0], 32'h2222_0000);
    check("arb1_rid", r_id[0], 12'h202);
    check("arb1_rlast", r_last[0], 1);

    // Arbitration round 2: read now wins
    set_aw(BASE + 32'h40, 4'd0, INC, 3'b010, 12'h103);
    set_ar(BASE + 32'h40, 4'd0, INC, 3'b010, 12'h204);
    arb_first(first);
    check("arb_round2_first", first, 2);
    @(posedge clk); #1 arvalid = 1'b0;
    get_r(1);
    check("arb2_rdata", r_data[0], 32'h2222_0000);
    wait_aw();
    send_w(1, 0, 32'h3333_0000);
    get_b();
    check("arb2_bresp", b_resp_s, 2'b00);
    check("arb2_bid", b_id_s, 12'h103);

    // INCR write of 4 beats at words 4..7
    base = log_n;
    set_aw(BASE + 32'h10, 4'd3, INC, 3'b010, 12'hABC);
    wait_aw();
    send_w(4, 3, 32'h1000_0000);
    get_b();
    check("incr_bresp", b_resp_s, 2'b00);
    check("incr_bid", b_id_s, 12'hABC);
    check("incr_beats", log_n - base, 4);
    for (int k = 0; k < 4; k++) begin
      check("incr_addr", log_addr[base + k], 8'(4 + k));
      check("incr_we", log_we[base + k], 1);
    end

    // WRAP read of 4 beats from word 6
    exp_addr[0] = 4'd6; exp_addr[1] = 4'd7; exp_addr[2] = 4'd4; exp_addr[3] = 4'd5;
    base = log_n;
    set_ar(BASE + 32'h18, 4'd3, WRP, 3'b010, 12'h3C5);
    wait_ar();
    get_r(4);
    check("wrap_beats", log_n - base, 4);
    for (int k = 0; k < 4; k++) begin
      check("wrap_addr", log_addr[base + k], 8'(exp_addr[k]));
      check("wrap_we", log_we[base + k], 0);
      check("wrap_rdata", r_data[k], 32'h1000_0000 + 32'(exp_addr[k] - 4'd4));
      check("wrap_rlast", r_last[k], (k == 3));
      check("wrap_rresp", r_resp[k], 2'b00);
      check("wrap_rid", r_id[k], 12'h3C5);
    end

`ifdef AXI_GP0_ERR_IRQ_EN
    check("irq_idle", err_irq, 0);
`endif

    // Out-of-window read: DECERR on both beats, no strobes
    base = log_n;
    set_ar(BASE + 32'h400, 4'd1, INC, 3'b010, 12'h011);
    wait_ar();
    get_r(2);
    for (int k = 0; k < 2; k++) begin
      check("dec_rresp", r_resp[k], 2'b11);
      check("dec_rdata", r_data[k], 32'd0);
      check("dec_rlast", r_last[k], (k == 1));
    end
    check("dec_no_reg_en", log_n - base, 0);

    // Narrow write: SLVERR, no strobes
    base = log_n;
    set_aw(BASE + 32'h20, 4'd0, INC, 3'b001, 12'h022);
    wait_aw();
    send_w(1, 0, 32'hDEAD_BEEF);
    get_b();
    check("size_bresp", b_resp_s, 2'b10);
    check("size_no_reg_en", log_n - base, 0);

    // Early wlast on 3-beat write: all beats written, SLVERR
    base = log_n;
    set_aw(BASE + 32'h30, 4'd2, INC, 3'b010, 12'h033);
    wait_aw();
    send_w(3, 1, 32'h5000_0000);
    get_b();
    check("wlast_bresp", b_resp_s, 2'b10);
    check("wlast_beats", log_n - base, 3);
    check("wlast_last_addr", log_addr[base + 2], 8'd14);

`ifdef AXI_GP0_ERR_IRQ_EN
    @(negedge clk);
    check("irq_status_set", err_status, 4'b1111);
    check("irq_set", err_irq, 1);
    err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("irq_status_clr", err_status, 4'b0000);
    check("irq_clr", err_irq, 0);
`endif

    // Stalled INCR read, then reset mid-burst
    set_ar(BASE + 32'h10, 4'd3, INC, 3'b010, 12'h05A);
    wait_ar();
    get_r(1);
    check("stall_beat0", r_data[0], 32'h1000_0000);
    begin
      int n = 0;
      @(negedge clk);
      while (!rvalid && n < 40) begin @(negedge clk); n++; end
    end
    check("stall_valid", rvalid, 1);
    for (int k = 0; k < 5; k++) begin
      check("stall_rdata", rdata, 32'h1000_0001);
      @(negedge clk);
    end
    base = log_n;
    #2 rst_n = 1'b0;
    #1;
    check("abort_rvalid", rvalid, 0);
    check("abort_rdata", rdata, 0);
    check("abort_rlast_rid", {rlast, rid}, 0);
    check("abort_readys", {awready, arready, wready, bvalid}, 0);
    check("abort_reg_en", reg_en, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("abort_no_more_reg_en", log_n - base, 0);
    check("abort_idle_rvalid", rvalid, 0);
    check("abort_idle_bvalid", bvalid, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
